vending_controller: RTL and testbench

VENDING_CONTROLLER -- requirements
Module: vending_controller

---
 rtl/vending_pkg.sv | 24 ++
 rtl/vending_controller_change_dispenser.sv | 68 ++++++
 rtl/vending_controller.sv | 123 ++++++++++++
 tb/tb_vending_controller.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared types and constants for the vending controller.
// Optional cancel/refund path is enabled by defining VEND_CANCEL_EN.
package vending_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DISPENSE,
        DENY,
        CHANGE,
        GAP
    } state_t;

    // Prices for sel 3..0, packed as nibbles, in 100-colon units
    localparam logic [15:0] PRICE_TABLE = {4'd12, 4'd8, 4'd5, 4'd3};

    localparam int UNIT_500 = 5;
    localparam int UNIT_100 = 1;

    function automatic logic [3:0] price_of(input logic [1:0] sel);
        return PRICE_TABLE[{sel, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/vending_controller_change_dispenser.sv
// Change sequencing: remainder register, gap counter and coin pulses.
// Loaded once per refund/change session; reports its final pulse.
import vending_pkg::*;

module change_dispenser #(
    parameter int CREDIT_W   = 8,
    parameter int CHANGE_GAP = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic [CREDIT_W-1:0] i_value,
    output logic                o_change_500,
    output logic                o_change_100,
    output logic                o_done,
    output logic                o_gap_end
);

    localparam logic [3:0] GAP_INIT =
        (CHANGE_GAP == 0) ? 4'd0 : 4'(CHANGE_GAP - 1);

    logic [CREDIT_W-1:0] r_rem;
    logic                r_active;
    logic                r_in_gap;
    logic [3:0]          r_gap_cnt;

    logic                w_pulse;
    logic                w_big;
    logic [CREDIT_W-1:0] w_step;
    logic [CREDIT_W-1:0] w_rem_next;

    assign w_pulse    = r_active && !r_in_gap;
    assign w_big      = r_rem >= CREDIT_W'(UNIT_500);
    assign w_step     = w_big ? CREDIT_W'(UNIT_500) : CREDIT_W'(UNIT_100);
    assign w_rem_next = r_rem - w_step;

    assign o_change_500 = w_pulse && w_big;
    assign o_change_100 = w_pulse && !w_big;
    assign o_done       = w_pulse && (w_rem_next == '0);
    assign o_gap_end    = r_active && r_in_gap && (r_gap_cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rem     <= '0;
            r_active  <= 1'b0;
            r_in_gap  <= 1'b0;
            r_gap_cnt <= 4'd0;
        end else if (i_load) begin
            r_rem     <= i_value;
            r_active  <= 1'b1;
            r_in_gap  <= 1'b0;
        end else if (r_active && r_in_gap) begin
            if (r_gap_cnt == 4'd0)
                r_in_gap  <= 1'b0;
            else
                r_gap_cnt <= r_gap_cnt - 4'd1;
        end else if (r_active) begin
            r_rem <= w_rem_next;
            if (w_rem_next == '0) begin
                r_active <= 1'b0;
            end else if (CHANGE_GAP != 0) begin
                r_in_gap  <= 1'b1;
                r_gap_cnt <= GAP_INIT;
            end
        end
    end

endmodule

// File: rtl/vending_controller.sv
// Vending controller top: purchase FSM plus change dispenser.
// Define VEND_CANCEL_EN to add the cancel/refund input.
import vending_pkg::*;

module vending_controller #(
    parameter int CREDIT_W   = 8,
    parameter int CHANGE_GAP = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CREDIT_W-1:0] credit,
    input  logic [1:0]          product_sel,
    input  logic                buy,
`ifdef VEND_CANCEL_EN
    input  logic                cancel,
`endif
    output logic                dispense,
    output logic                deny,
    output logic                change_500,
    output logic                change_100,
    output logic                counter_clear,
    output logic                busy
);

    state_t              r_state;
    state_t              w_state_next;
    logic [CREDIT_W-1:0] r_credit;
    logic [1:0]          r_sel;

    logic [CREDIT_W-1:0] w_price;
    logic [CREDIT_W-1:0] w_remainder;
    logic                w_afford;
    logic                w_cancel_go;
    logic                w_load;
    logic [CREDIT_W-1:0] w_load_val;
    logic                w_done;
    logic                w_gap_end;

    assign w_price     = CREDIT_W'(price_of(r_sel));
    assign w_afford    = r_credit >= w_price;
    assign w_remainder = r_credit - w_price;
    assign busy        = r_state != IDLE;

`ifdef VEND_CANCEL_EN
    assign w_cancel_go = cancel && (credit != '0);
`else
    assign w_cancel_go = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_credit <= '0;
            r_sel    <= 2'd0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && buy) begin
                r_credit <= credit;
                r_sel    <= product_sel;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        dispense      = 1'b0;
        deny          = 1'b0;
        counter_clear = 1'b0;
        w_load        = 1'b0;
        w_load_val    = w_remainder;
        unique case (r_state)
            IDLE: begin
                // Refund takes priority over a simultaneous purchase
                if (w_cancel_go) begin
                    counter_clear = 1'b1;
                    w_load        = 1'b1;
                    w_load_val    = credit;
                    w_state_next  = CHANGE;
                end else if (buy) begin
                    w_state_next = CHECK;
                end
            end
            CHECK: w_state_next = w_afford ? DISPENSE : DENY;
            DISPENSE: begin
                dispense      = 1'b1;
                counter_clear = 1'b1;
                if (w_remainder != '0) begin
                    w_load       = 1'b1;
                    w_state_next = CHANGE;
                end else begin
                    w_state_next = IDLE;
                end
            end
            DENY: begin
                deny         = 1'b1;
                w_state_next = IDLE;
            end
            CHANGE: begin
                if (w_done)
                    w_state_next = IDLE;
                else if (CHANGE_GAP != 0)
                    w_state_next = GAP;
            end
            GAP: if (w_gap_end) w_state_next = CHANGE;
            default: w_state_next = IDLE;
        endcase
    end

    change_dispenser #(
        .CREDIT_W   (CREDIT_W),
        .CHANGE_GAP (CHANGE_GAP)
    ) u_change (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_load),
        .i_value      (w_load_val),
        .o_change_500 (change_500),
        .o_change_100 (change_100),
        .o_done       (w_done),
        .o_gap_end    (w_gap_end)
    );

endmodule

// File: tb/tb_vending_controller.sv
// Directed self-checking bench for vending_controller.
// Output vector order: {dispense, deny, change_500, change_100, counter_clear, busy}.
module tb_vending_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] credit = 8'd0;
    logic [1:0] product_sel = 2'd0;
    logic       buy = 1'b0;
    logic       cancel = 1'b0;
    logic       dispense, deny, change_500, change_100, counter_clear, busy;

    int tests = 0;
    int fails = 0;
    int units = 0;
    int disp_cnt = 0;

    always #5 clk = ~clk;

    vending_controller #(.CREDIT_W(8), .CHANGE_GAP(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .credit        (credit),
        .product_sel   (product_sel),
        .buy           (buy),
`ifdef VEND_CANCEL_EN
        .cancel        (cancel),
`endif
        .dispense      (dispense),
        .deny          (deny),
        .change_500    (change_500),
        .change_100    (change_100),
        .counter_clear (counter_clear),
        .busy          (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {dispense, deny, change_500, change_100, counter_clear, busy};
        units    += (obs[3] ? 5 : 0) + (obs[2] ? 1 : 0);
        disp_cnt += obs[5] ? 1 : 0;
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset
        tick();
        tick();
        chk("reset", 6'b000000);
        reset = 1'b1;
        tick();
        chk("idle_after_reset", 6'b000000);

        // Exact price, no change
        credit = 8'd5; product_sel = 2'd1; buy = 1'b1;
        tick();
        buy = 1'b0;
        chk("p5_check", 6'b000001);
        tick();
        chk("p5_dispense", 6'b100011);
        tick();
        chk("p5_idle", 6'b000000);

        // 12 credit, price 3 -> 9 units change; buy held during change
        units = 0; disp_cnt = 0;
        credit = 8'd12; product_sel = 2'd0; buy = 1'b1;
        tick();
        buy = 1'b0;
        chk("c12_check", 6'b000001);
        tick();
        chk("c12_dispense", 6'b100011);
        tick();
        chk("c12_c500", 6'b001001);
        buy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("c12_gap_a", 6'b000001);
            tick();
            chk("c12_gap_b", 6'b000001);
            tick();
            chk("c12_c100", 6'b000101);
        end
        buy = 1'b0;
        tick();
        chk("c12_idle", 6'b000000);
        tick();
        chk("c12_still_idle", 6'b000000);
        chk_int("c12_units", units, 9);
        chk_int("c12_one_dispense", disp_cnt, 1);

        // Insufficient credit
        credit = 8'd7; product_sel = 2'd2; buy = 1'b1;
        tick();
        buy = 1'b0;
        chk("c7_check", 6'b000001);
        tick();
        chk("c7_deny", 6'b010001);
        tick();
        chk("c7_idle", 6'b000000);

        // Zero credit
        credit = 8'd0; product_sel = 2'd0; buy = 1'b1;
        tick();
        buy = 1'b0;
        chk("c0_check", 6'b000001);
        tick();
        chk("c0_deny", 6'b010001);
        tick();
        chk("c0_idle", 6'b000000);

        // Most expensive item, exact credit
        credit = 8'd12; product_sel = 2'd3; buy = 1'b1;
        tick();
        buy = 1'b0;
        tick();
        chk("p12_dispense", 6'b100011);
        tick();
        chk("p12_idle", 6'b000000);

        // Reset during second change pulse
        units = 0;
        credit = 8'd12; product_sel = 2'd0; buy = 1'b1;
        tick();
        buy = 1'b0;
        tick();
        chk("rst_dispense", 6'b100011);
        tick();
        chk("rst_c500", 6'b001001);
        tick();
        tick();
        tick();
        chk("rst_c100", 6'b000101);
        reset = 1'b0;
        tick();
        chk("rst_outputs_zero", 6'b000000);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        chk("rst_no_more_change", 6'b000000);
        chk_int("rst_units", units, 6);

`ifdef VEND_CANCEL_EN
        // Cancel wins over buy: 6 units refunded as 500 + 100
        disp_cnt = 0;
        credit = 8'd6; product_sel = 2'd0; buy = 1'b1; cancel = 1'b1;
        #1;
        chk("cx_clear", 6'b000010);
        tick();
        buy = 1'b0; cancel = 1'b0;
        chk("cx_c500", 6'b001001);
        tick();
        tick();
        tick();
        chk("cx_c100", 6'b000101);
        tick();
        chk("cx_idle", 6'b000000);
        chk_int("cx_no_dispense", disp_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
